// File: rtl/clk_seq_pkg.sv
// Shared types and select encodings for the test-clock select sequencer.
// The state enum is also visible to anything that wants to decode the sequencer's progress.
package clk_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      IDLE      = 2'd1,
      GATE_OFF  = 2'd2,
      SETTLE    = 2'd3
   } seq_state_t;

   localparam logic [1:0] SEL_100M = 2'b00;
   localparam logic [1:0] SEL_10M  = 2'b01;
   localparam logic [1:0] SEL_1M   = 2'b10;
   localparam logic [1:0] SEL_100K = 2'b11;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// It has a synchronous active-low reset, so the synchronized level reads 0 coming out of reset.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_b_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (!rst_b_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/clk_sel_sequencer.sv
// Sequences changes of the 2-bit test-clock mux select. The DUT clock is gated off, the select changes,
// the clock settles, and the clock is re-enabled. The DUT clock stays gated until the PLL lock is stable.
module clk_sel_sequencer
   import clk_seq_pkg::*;
#(
   parameter logic [1:0] DEFAULT_SEL     = SEL_100M,
   parameter int         LOCK_STABLE_CYC = 32,
   parameter int         GATE_CYC        = 16,
   parameter int         SETTLE_CYC      = 64,
   parameter int         CNT_W           = 8
) (
   input  logic       CLK_50M,
   input  logic       RST_B,
   input  logic       PLL_LOCKED,
   input  logic       REQ_VALID,
   input  logic [1:0] REQ_SEL,
   output logic       REQ_READY,
   input  logic       ERR_CLR,
   output logic [1:0] CLK_CTL,
   output logic       CLK_EN,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR
);

   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   seq_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       sel_q;
   logic [1:0]       ctl_q;
   logic             en_q;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic             lockS;
   logic             lockLoss;

   sync_2ff u_lock_sync (
      .clk_i   (CLK_50M),
      .rst_b_i (RST_B),
      .d_i     (PLL_LOCKED),
      .q_o     (lockS)
   );

   // Losing lock outside WAIT_LOCK overrides whatever the current state would otherwise do.
   assign lockLoss = !lockS && (state_q != WAIT_LOCK);

   always_ff @(posedge CLK_50M) begin
      if (!RST_B) begin
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         sel_q   <= DEFAULT_SEL;
         ctl_q   <= DEFAULT_SEL;
         en_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (ERR_CLR) begin
            err_q <= 1'b0;
         end
         if (lockLoss) begin
            // An in-flight request is dropped and CLK_CTL keeps its present value.
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
         end else begin
            case (state_q)
               WAIT_LOCK: begin
                  if (!lockS) begin
                     cnt_q <= '0;
                  end else if (cnt_q == LOCK_LAST) begin
                     cnt_q   <= '0;
                     state_q <= IDLE;
                     en_q    <= 1'b1;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               IDLE: begin
                  if (REQ_VALID && ready_q) begin
                     if (REQ_SEL == ctl_q) begin
                        done_q <= 1'b1;
                     end else begin
                        sel_q   <= REQ_SEL;
                        en_q    <= 1'b0;
                        cnt_q   <= GATE_LOAD;
                        state_q <= GATE_OFF;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                     end
                  end
               end
               GATE_OFF: begin
                  if (cnt_q == '0) begin
                     ctl_q   <= sel_q;
                     cnt_q   <= SETTLE_LOAD;
                     state_q <= SETTLE;
                  end else begin
                     cnt_q <= cnt_q - CNT_ONE;
                  end
               end
               SETTLE: begin
                  if (cnt_q == '0) begin
                     en_q    <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q - CNT_ONE;
                  end
               end
               default: begin
                  state_q <= WAIT_LOCK;
                  cnt_q   <= '0;
                  en_q    <= 1'b0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            endcase
         end
      end
   end

   assign CLK_CTL   = ctl_q;
   assign CLK_EN    = en_q;
   assign REQ_READY = ready_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign ERR       = err_q;

endmodule

// File: tb/tb_clk_sel_sequencer.sv
// Self-checking bench for clk_sel_sequencer. A cycle-timeline model is compared against the DUT on
// every falling edge, and directed scenarios also check literal edge counts and output values.
module tb_clk_sel_sequencer;
   import clk_seq_pkg::*;

   localparam int LOCK_N   = 32;
   localparam int GATE_N   = 16;
   localparam int SETTLE_N = 64;
   localparam int M_WAIT   = 0;
   localparam int M_IDLE   = 1;
   localparam int M_SEQ    = 2;

   logic       clk = 1'b0;
   logic       rstB;
   logic       pllLocked;
   logic       reqValid;
   logic [1:0] reqSel;
   logic       errClr;
   logic       reqReady;
   logic [1:0] clkCtl;
   logic       clkEn;
   logic       busy;
   logic       done;
   logic       err;

   int checkCount = 0;
   int errorCount = 0;

   // Model state: the lock history, an operating mode and the elapsed time of the current request.
   bit       modelLive = 0;
   bit       mLock1, mLock2, lockOld;
   int       mMode, mStable, mElapsed;
   bit [1:0] mTarget, mCtl;
   bit       mEn, mDone, mErr;

   clk_sel_sequencer dut (
      .CLK_50M    (clk),
      .RST_B      (rstB),
      .PLL_LOCKED (pllLocked),
      .REQ_VALID  (reqValid),
      .REQ_SEL    (reqSel),
      .REQ_READY  (reqReady),
      .ERR_CLR    (errClr),
      .CLK_CTL    (clkCtl),
      .CLK_EN     (clkEn),
      .BUSY       (busy),
      .DONE       (done),
      .ERR        (err)
   );

   always #5 clk = ~clk;

   // Advance the timeline model on every rising edge from the inputs the DUT samples at that edge.
   always @(posedge clk) begin
      if (!rstB) begin
         modelLive = 1;
         mLock1 = 0; mLock2 = 0;
         mMode = M_WAIT; mStable = 0; mElapsed = 0;
         mTarget = SEL_100M; mCtl = SEL_100M;
         mEn = 0; mDone = 0; mErr = 0;
      end else begin
         lockOld = mLock2;
         mLock2 = mLock1;
         mLock1 = pllLocked;
         mDone = 0;
         if (errClr) mErr = 0;
         if (mMode == M_WAIT) begin
            mStable = lockOld ? mStable + 1 : 0;
            if (mStable == LOCK_N) begin
               mMode = M_IDLE;
               mEn = 1;
            end
         end else if (!lockOld) begin
            mMode = M_WAIT; mStable = 0; mEn = 0; mErr = 1;
         end else if (mMode == M_IDLE) begin
            if (reqValid) begin
               if (reqSel == mCtl) begin
                  mDone = 1;
               end else begin
                  mMode = M_SEQ; mTarget = reqSel; mElapsed = 0; mEn = 0;
               end
            end
         end else begin
            mElapsed++;
            if (mElapsed == GATE_N) mCtl = mTarget;
            if (mElapsed == GATE_N + SETTLE_N) begin
               mEn = 1; mDone = 1; mMode = M_IDLE;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (modelLive) begin
         checkOutput("model CLK_CTL",   32'(clkCtl),   32'(mCtl));
         checkOutput("model CLK_EN",    32'(clkEn),    32'(mEn));
         checkOutput("model REQ_READY", 32'(reqReady), 32'(mMode == M_IDLE));
         checkOutput("model BUSY",      32'(busy),     32'(mMode != M_IDLE));
         checkOutput("model DONE",      32'(done),     32'(mDone));
         checkOutput("model ERR",       32'(err),      32'(mErr));
      end
   end

   task automatic applyStimulus(input logic rst, input logic pll, input logic valid,
                                input logic [1:0] sel, input logic clr);
      @(negedge clk);
      rstB = rst; pllLocked = pll; reqValid = valid; reqSel = sel; errClr = clr;
   endtask

   // Count rising edges until a condition holds: 0 = CLK_EN high, 1 = DONE high, 2 = CLK_CTL is 1M.
   task automatic countUntil(input int which, input int budget, output int n);
      bit hit = 0;
      n = 0;
      while (!hit && n < budget) begin
         @(posedge clk); #1;
         n++;
         case (which)
            0:       hit = clkEn;
            1:       hit = done;
            default: hit = (clkCtl == SEL_1M);
         endcase
      end
      if (!hit) begin
         checkCount++;
         errorCount++;
         $display("[TB] FAIL wait timeout: condition %0d not seen within %0d edges", which, budget);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      rstB = 0; pllLocked = 0; reqValid = 0; reqSel = SEL_100M; errClr = 0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset CLK_EN", 32'(clkEn), 32'd0);
      checkOutput("reset BUSY", 32'(busy), 32'd1);
      checkOutput("reset REQ_READY", 32'(reqReady), 32'd0);
      checkOutput("reset CLK_CTL", 32'(clkCtl), 32'd0);
      checkOutput("reset ERR", 32'(err), 32'd0);

      $display("[TB] initial lock");
      applyStimulus(1, 1, 0, SEL_100M, 0);
      countUntil(0, 100, n);
      checkOutput("lock to enable edges", 32'(n), 32'd34);
      checkOutput("ready after lock", 32'(reqReady), 32'd1);

      $display("[TB] switch to 1M");
      applyStimulus(1, 1, 1, SEL_1M, 0);
      @(posedge clk); #1;
      checkOutput("gate on accept", 32'(clkEn), 32'd0);
      checkOutput("ready drops on accept", 32'(reqReady), 32'd0);
      applyStimulus(1, 1, 0, SEL_1M, 0);
      countUntil(2, 40, n);
      checkOutput("gate to select edges", 32'(n), 32'd16);
      countUntil(1, 100, n);
      checkOutput("select to done edges", 32'(n), 32'd64);
      checkOutput("enable at done", 32'(clkEn), 32'd1);

      $display("[TB] same-select request");
      applyStimulus(1, 1, 1, SEL_1M, 0);
      @(posedge clk); #1;
      checkOutput("same-select DONE", 32'(done), 32'd1);
      checkOutput("same-select CLK_EN", 32'(clkEn), 32'd1);
      checkOutput("same-select CLK_CTL", 32'(clkCtl), 32'(SEL_1M));
      applyStimulus(1, 1, 0, SEL_1M, 0);

      $display("[TB] lock loss in GATE_OFF");
      applyStimulus(1, 1, 1, SEL_10M, 0);
      @(posedge clk); #1;
      applyStimulus(1, 1, 0, SEL_10M, 0);
      repeat (9) @(posedge clk);
      applyStimulus(1, 0, 0, SEL_10M, 0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("ERR before loss seen", 32'(err), 32'd0);
      @(posedge clk); #1;
      checkOutput("loss ERR", 32'(err), 32'd1);
      checkOutput("loss CLK_EN", 32'(clkEn), 32'd0);
      checkOutput("loss CLK_CTL kept", 32'(clkCtl), 32'(SEL_1M));
      checkOutput("loss DONE", 32'(done), 32'd0);
      applyStimulus(1, 1, 0, SEL_10M, 0);
      countUntil(0, 100, n);
      checkOutput("relock edges", 32'(n), 32'd34);
      checkOutput("relock CLK_CTL", 32'(clkCtl), 32'(SEL_1M));

      $display("[TB] ERR clear against set");
      applyStimulus(1, 1, 0, SEL_10M, 1);
      @(posedge clk); #1;
      checkOutput("ERR cleared", 32'(err), 32'd0);
      applyStimulus(1, 0, 0, SEL_10M, 0);
      repeat (2) @(posedge clk);
      applyStimulus(1, 0, 0, SEL_10M, 1);
      @(posedge clk); #1;
      checkOutput("set beats clear", 32'(err), 32'd1);
      applyStimulus(1, 0, 0, SEL_10M, 1);
      @(posedge clk); #1;
      checkOutput("clear alone", 32'(err), 32'd0);
      applyStimulus(1, 1, 0, SEL_10M, 0);
      countUntil(0, 100, n);
      checkOutput("relock after clear", 32'(n), 32'd34);

      $display("[TB] reset during SETTLE");
      applyStimulus(1, 1, 1, SEL_100K, 0);
      @(posedge clk); #1;
      applyStimulus(1, 1, 0, SEL_100K, 0);
      repeat (24) @(posedge clk);
      applyStimulus(0, 1, 1, SEL_10M, 0);
      @(posedge clk); #1;
      checkOutput("mid reset CLK_CTL", 32'(clkCtl), 32'(SEL_100M));
      checkOutput("mid reset CLK_EN", 32'(clkEn), 32'd0);
      checkOutput("mid reset BUSY", 32'(busy), 32'd1);
      checkOutput("mid reset REQ_READY", 32'(reqReady), 32'd0);
      applyStimulus(1, 1, 1, SEL_10M, 0);
      countUntil(0, 100, n);
      checkOutput("held request waits for lock", 32'(n), 32'd34);
      @(posedge clk); #1;
      checkOutput("held request accepted", 32'(clkEn), 32'd0);
      applyStimulus(1, 1, 0, SEL_10M, 0);
      countUntil(1, 120, n);
      checkOutput("full sequence edges", 32'(n), 32'd80);
      checkOutput("final CLK_CTL", 32'(clkCtl), 32'(SEL_10M));

      repeat (2) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
